// File: rtl/button_conditioner_pkg.sv
// Shared types and timing constants for the quiz button front end.
// Arm FSM encoding plus the default 10 ms debounce length at CLK_HZ.
package button_conditioner_pkg;

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } arm_state_t;

    localparam int CLK_HZ = 10_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int DEBOUNCE_CYCLES_10MS =
        CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/btn_debounce_bit.sv
// One button: two-flop synchroniser, run-length counter, debounced level.
// rise flags the cycle whose clock edge will raise the level.
module btn_debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
    parameter int CNT_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             expire;

    assign differ = sync_q[1] ^ level;
    assign expire = differ && (cnt == LAST);
    assign rise   = expire && !level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            // any return to the old level discards progress
            if (!differ) begin
                cnt <= '0;
            end else if (expire) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Quiz button front end: per-bit debounce, press pulses, priority code
// and an arm/lock FSM accepting one press per full release.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN = 7,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
    parameter int CNT_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               any_level,
    output logic               press_strobe,
    output logic [2:0]         press_code,
    output logic               locked
);

    if (NUM_BTN < 1 || NUM_BTN > 7 || DEBOUNCE_CYCLES < 1 ||
        (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_param
        $error("button_conditioner: illegal parameters");
    end

    logic [NUM_BTN-1:0] rise;
    arm_state_t         state_q;
    arm_state_t         state_d;
    logic [2:0]         enc;
    logic [2:0]         code_d;
    logic               strobe_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_bit
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_bit (
            .clk(clk),
            .rst_n(rst_n),
            .raw(btn_raw[i]),
            .level(btn_level[i]),
            .rise(rise[i])
        );
    end

    assign any_level = |btn_level;

    // scan downward so the lowest set bit has the last word
    always_comb begin
        enc = 3'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (btn_level[i]) enc = 3'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARMED;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED:  if (any_level)  state_d = LOCKED;
            LOCKED: if (!any_level) state_d = ARMED;
            default: state_d = ARMED;
        endcase
    end

    always_comb begin
        locked   = (state_q == LOCKED);
        strobe_d = (state_q == ARMED) && any_level;
        code_d   = strobe_d ? enc : press_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_pulse    <= '0;
            press_strobe <= 1'b0;
            press_code   <= 3'd0;
        end else begin
            btn_pulse    <= rise;
            press_strobe <= strobe_d;
            press_code   <= code_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: history-based reference model checked
// every cycle, a scenario table, directed corner sequences, random run.
module tb_button_conditioner;

    localparam int N  = 7;
    localparam int DC = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;
    logic         any_level;
    logic         press_strobe;
    logic [2:0]   press_code;
    logic         locked;

    button_conditioner #(
        .NUM_BTN(N),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_level(any_level),
        .press_strobe(press_strobe),
        .press_code(press_code),
        .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // raw value sampled at each clock edge since the last reset
    logic [N-1:0] hist[$];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_pulse = '0;
    logic         m_strobe = 1'b0;
    logic         m_armed = 1'b1;
    logic [2:0]   m_code = 3'd0;

    int           n_strobe;
    int           n_pulse_cyc;
    logic [N-1:0] pulse_or;

    typedef struct {
        logic [N-1:0] raw;
        int           ncyc;
        logic [N-1:0] exp_level;
        logic         exp_locked;
        logic [2:0]   exp_code;
        int           exp_strobes;
        logic [N-1:0] exp_pulse_or;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] lowest_code(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    function automatic logic [N-1:0] sampled(input int idx);
        if (idx < 1) return '0;
        return hist[idx - 1];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_level  = '0;
        m_pulse  = '0;
        m_strobe = 1'b0;
        m_armed  = 1'b1;
        m_code   = 3'd0;
    endtask

    // A bit flips once DC consecutive delayed samples all disagree with it.
    task automatic model_edge();
        int           t;
        logic [N-1:0] nl;
        logic [N-1:0] s;
        logic         any_prev;
        t = hist.size();
        nl = m_level;
        any_prev = |m_level;
        for (int i = 0; i < N; i++) begin
            bit run = 1'b1;
            for (int k = 2; k <= DC + 1; k++) begin
                s = sampled(t - k);
                if (s[i] == m_level[i]) run = 1'b0;
            end
            if (run) nl[i] = ~m_level[i];
        end
        m_pulse  = nl & ~m_level;
        m_strobe = m_armed && any_prev;
        if (m_strobe) m_code = lowest_code(m_level);
        m_armed  = !any_prev;
        m_level  = nl;
    endtask

    task automatic step(input logic [N-1:0] r);
        btn_raw = r;
        @(posedge clk);
        hist.push_back(r);
        model_edge();
        #1;
        check("model", {btn_level, btn_pulse, any_level, press_strobe,
                        press_code, locked},
              {m_level, m_pulse, |m_level, m_strobe, m_code, !m_armed});
        n_strobe    += int'(press_strobe);
        n_pulse_cyc += int'(btn_pulse != '0);
        pulse_or    |= btn_pulse;
    endtask

    task automatic clear_counts();
        n_strobe    = 0;
        n_pulse_cyc = 0;
        pulse_or    = '0;
    endtask

    task automatic release_all();
        repeat (10) step('0);
        clear_counts();
    endtask

    // From released/armed: level at edge DC+2, strobe one edge later.
    task automatic press_timing(input string name, input logic [N-1:0] r,
                                input logic [2:0] code);
        for (int e = 1; e <= 8; e++) begin
            step(r);
            if (e == DC + 1) check({name, "_early"}, btn_level, 0);
            if (e == DC + 2) begin
                check({name, "_level"}, btn_level, r);
                check({name, "_pulse"}, btn_pulse, r);
                check({name, "_nostrobe"}, press_strobe, 0);
            end
            if (e == DC + 3) begin
                check({name, "_strobe"}, press_strobe, 1);
                check({name, "_code"}, press_code, code);
                check({name, "_locked"}, locked, 1);
                check({name, "_pulse_end"}, btn_pulse, 0);
            end
            if (e == DC + 4) check({name, "_strobe_end"}, press_strobe, 0);
        end
    endtask

    vec_t vecs[9];
    logic [N-1:0] cur;
    logic [N-1:0] r;
    logic [3:0]   bounce;

    initial begin
        vecs[0] = '{7'h00, 10, 7'h00, 1'b0, 3'd1, 0, 7'h00};
        vecs[1] = '{7'h04, 10, 7'h04, 1'b1, 3'd3, 1, 7'h04};
        vecs[2] = '{7'h00, 10, 7'h00, 1'b0, 3'd3, 0, 7'h00};
        vecs[3] = '{7'h01, 10, 7'h01, 1'b1, 3'd1, 1, 7'h01};
        vecs[4] = '{7'h41, 10, 7'h41, 1'b1, 3'd1, 0, 7'h40};
        vecs[5] = '{7'h40, 10, 7'h40, 1'b1, 3'd1, 0, 7'h00};
        vecs[6] = '{7'h00, 10, 7'h00, 1'b0, 3'd1, 0, 7'h00};
        vecs[7] = '{7'h40, 10, 7'h40, 1'b1, 3'd7, 1, 7'h40};
        vecs[8] = '{7'h00, 10, 7'h00, 1'b0, 3'd7, 0, 7'h00};

        // reset with every button already held
        btn_raw = 7'h7F;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_outs", {btn_level, btn_pulse, any_level,
                             press_strobe, press_code, locked}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", {btn_level, press_strobe, press_code,
                             locked}, 0);
        rst_n = 1'b1;
        clear_counts();
        press_timing("reset_release", 7'h7F, 3'd1);

        for (int v = 0; v < 9; v++) begin
            clear_counts();
            repeat (vecs[v].ncyc) step(vecs[v].raw);
            check($sformatf("vec%0d_level", v), btn_level,
                  vecs[v].exp_level);
            check($sformatf("vec%0d_locked", v), locked,
                  vecs[v].exp_locked);
            check($sformatf("vec%0d_code", v), press_code,
                  vecs[v].exp_code);
            check($sformatf("vec%0d_strobes", v), n_strobe,
                  vecs[v].exp_strobes);
            check($sformatf("vec%0d_pulses", v), pulse_or,
                  vecs[v].exp_pulse_or);
        end

        release_all();
        press_timing("clean_press", 7'h04, 3'd3);

        // bounce on btn5, then settle high
        release_all();
        bounce = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            step(bounce[i / 2] ? 7'h10 : 7'h00);
        end
        check("bounce_quiet", pulse_or | btn_level, 0);
        for (int e = 1; e <= 12; e++) begin
            step(7'h10);
            if (e == DC + 1) check("bounce_early", btn_level, 0);
            if (e == DC + 2) check("bounce_level", btn_level, 7'h10);
        end
        check("bounce_pulses", n_pulse_cyc, 1);
        check("bounce_strobes", n_strobe, 1);
        check("bounce_code", press_code, 5);

        release_all();
        press_timing("simult", 7'h28, 3'd4);

        // reset while locked with btn2 held
        release_all();
        repeat (10) step(7'h02);
        check("midlock_locked", locked, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midlock_clear", {locked, press_code, btn_level}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= DC + 3; e++) begin
            step(7'h02);
            if (e == DC + 2) check("midlock_nostrobe", press_strobe, 0);
        end
        check("midlock_strobe", press_strobe, 1);
        check("midlock_code", press_code, 2);

        // random holds with single-cycle glitches
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) cur = N'($urandom);
            r = cur;
            if ($urandom_range(0, 7) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            if (c == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_reset", {btn_level, press_code, locked}, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            step(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
